sipo_frame_rx: RTL and testbench

//   Serial frame receiver: the receiving end of the team's MSB-first serial bit stream.

---
 rtl/sipo_frame_rx.sv | 114 +++++++++++
 tb/tb_sipo_frame_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx - serial frame receiver, MSB first.
//   Waits for a start bit (1), then shifts in WIDTH data bits and an optional
//   parity bit. Each received word goes into a one-deep holding register that
//   the consumer drains with a valid/ready handshake.
// Ports:
//   clk, rst          clock, async active-high reset
//   serial_in, bit_en serial line and bit strobe (one bit per strobed edge)
//   data_out          received word
//   data_valid        data_out holds an unconsumed word
//   data_ready        consumer takes the word on data_valid && data_ready
//   parity_err        parity mismatch for the word on data_out
//   overrun           sticky: a completed word was dropped (holding reg full)
//   overrun_clr       synchronous clear of overrun (a new overrun wins)
//   busy              frame in progress
module sipo_frame_rx #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_perr;
  logic             r_ovr;

  logic [WIDTH-1:0] w_shift;
  logic             w_last_data;
  logic             w_deliver;
  logic             w_can_load;
  logic [WIDTH-1:0] w_word;
  logic             w_exp_par;
  logic             w_perr;

  assign w_shift     = {r_sreg[WIDTH-2:0], serial_in};
  assign w_last_data = bit_en && (r_state == DATA) && (r_cnt == CW'(WIDTH-1));

  // With parity the word is already complete in r_sreg when the parity bit
  // arrives; without it, the word includes the bit sampled on this edge.
  assign w_exp_par = (^r_sreg) ^ (PARITY_ODD != 0);
  assign w_deliver = (PARITY_EN != 0) ? (bit_en && (r_state == PARITY)) : w_last_data;
  assign w_word    = (PARITY_EN != 0) ? r_sreg : w_shift;
  assign w_perr    = (PARITY_EN != 0) ? (serial_in ^ w_exp_par) : 1'b0;

  // The holding register can take a new word if empty or drained this edge.
  assign w_can_load = !r_valid || data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (serial_in) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_sreg <= w_shift;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last_data)
              r_state <= (PARITY_EN != 0) ? PARITY : IDLE;
          end
          PARITY:  r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end

      if (w_deliver && w_can_load) begin
        r_data  <= w_word;
        r_perr  <= w_perr;
        r_valid <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end

      if (w_deliver && !w_can_load) r_ovr <= 1'b1;
      else if (overrun_clr)         r_ovr <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx (WIDTH=8, even parity).
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       bit_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       overrun;
  logic       overrun_clr;
  logic       busy;

  int errors = 0;
  int checks = 0;

  sipo_frame_rx #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .bit_en      (bit_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle `gap` cycles with the line toggling, then one strobed bit.
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bit_en    = 1'b0;
      serial_in = ~serial_in;
      tick();
    end
    serial_in = b;
    bit_en    = 1'b1;
    tick();
    bit_en    = 1'b0;
    serial_in = ~b;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
    send_bit(1'b1, gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
    send_bit(p, gap);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'h7F, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0};

    rst = 1'b1; serial_in = 1'b0; bit_en = 1'b0;
    data_ready = 1'b1; overrun_clr = 1'b0;
    tick(); tick();
    chk("reset data_out", data_out, 0);
    chk("reset valid", data_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    rst = 1'b0;
    tick();

    // Table: single frames, consumer always ready.
    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].data, vecs[k].par, 0);
      chk($sformatf("vec%0d data", k), data_out, vecs[k].data);
      chk($sformatf("vec%0d valid", k), data_valid, 1);
      chk($sformatf("vec%0d perr", k), parity_err, vecs[k].exp_perr);
      chk($sformatf("vec%0d busy", k), busy, 0);
      tick();
      chk($sformatf("vec%0d valid drop", k), data_valid, 0);
      chk($sformatf("vec%0d overrun", k), overrun, 0);
    end

    // Overrun: second word dropped while holding register is full.
    data_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 0);
    chk("ovr data held", data_out, 8'h3C);
    chk("ovr valid", data_valid, 1);
    chk("ovr flag", overrun, 1);
    tick();
    chk("ovr sticky", overrun, 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ovr cleared", overrun, 0);
    chk("ovr data still", data_out, 8'h3C);
    // Consumer drains on the same edge as the final bit: new word loads.
    send_bit(1'b1, 0);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, 0);
    data_ready = 1'b1;
    send_bit(1'b0, 0);
    chk("drain+load data", data_out, 8'hFF);
    chk("drain+load valid", data_valid, 1);
    chk("drain+load overrun", overrun, 0);
    tick();
    chk("drain+load consumed", data_valid, 0);

    // Sparse strobes with line glitching in between.
    send_frame(8'hA5, 1'b0, 3);
    chk("sparse data", data_out, 8'hA5);
    chk("sparse perr", parity_err, 0);
    chk("sparse valid", data_valid, 1);
    tick();

    // Mid-frame reset with a full holding register and overrun set.
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    send_bit(1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    chk("pre-reset busy", busy, 1);
    chk("pre-reset overrun", overrun, 1);
    rst = 1'b1;
    #1;
    chk("rst data_out", data_out, 0);
    chk("rst valid", data_valid, 0);
    chk("rst overrun", overrun, 0);
    chk("rst busy", busy, 0);
    tick();
    rst = 1'b0;
    data_ready = 1'b1;
    tick();
    send_frame(8'h5A, 1'b0, 0);
    chk("post-rst data", data_out, 8'h5A);
    chk("post-rst valid", data_valid, 1);
    chk("post-rst perr", parity_err, 0);
    tick();

    // Back-to-back frames, no idle bit between them.
    begin
      logic [7:0] d0, d1;
      int busy_bad;
      d0 = 8'h01; d1 = 8'h80; busy_bad = 0;
      send_bit(1'b1, 0);
      if (!busy) busy_bad++;
      for (int i = 7; i >= 0; i--) begin send_bit(d0[i], 0); if (!busy) busy_bad++; end
      send_bit(1'b1, 0);
      chk("b2b first data", data_out, 8'h01);
      chk("b2b first valid", data_valid, 1);
      send_bit(1'b1, 0);
      chk("b2b first consumed", data_valid, 0);
      if (!busy) busy_bad++;
      for (int i = 7; i >= 0; i--) begin send_bit(d1[i], 0); if (!busy) busy_bad++; end
      send_bit(1'b1, 0);
      chk("b2b second data", data_out, 8'h80);
      chk("b2b second valid", data_valid, 1);
      chk("b2b busy throughout", busy_bad, 0);
      tick();
      chk("b2b done valid", data_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
